// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: fetches one instruction per step
// over a req/ready handshake and selects the next PC from the decoder's Branch code.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Branch,
  input  logic [31:0] rs_data,
  input  logic        step,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        run;
  logic        fetch_hit;
  logic        exec_step;
  logic        misaligned;
  logic [31:0] pc_nxt;

  // Next-PC mux; the branch offset is a signed word count, so wrap works both ways.
  function automatic logic [31:0] next_pc(
    input logic [1:0]  sel,
    input logic [31:0] pc4,
    input logic [25:0] ir,
    input logic [31:0] rs
  );
    logic signed [31:0] br_off;
    br_off = signed'({{14{ir[15]}}, ir[15:0], 2'b00});
    case (sel)
      2'b00:   next_pc = pc4;
      2'b01:   next_pc = pc4 + unsigned'(br_off);
      2'b10:   next_pc = {pc4[31:28], ir, 2'b00};
      default: next_pc = rs;
    endcase
  endfunction

  assign pc_plus4   = pc + 32'd4;
  assign imem_addr  = pc;
  assign pc_nxt     = next_pc(Branch, pc_plus4, inst[25:0], rs_data);
  assign misaligned = |pc_nxt[1:0];
  assign fetch_hit  = imem_req && imem_ready;
  assign exec_step  = (state == EXEC) && step;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (fetch_hit) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (step) begin
          state_nxt = misaligned ? HALT : FETCH;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Output decode; run keeps imem_req low until the first edge after reset release
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      FETCH:   imem_req   = run;
      EXEC:    inst_valid = 1'b1;
      default: begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
      end
    endcase
  end

  // PC, instruction latch and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run      <= 1'b0;
      pc       <= RESET_PC;
      inst     <= 32'd0;
      addr_err <= 1'b0;
    end else begin
      run <= 1'b1;
      if (fetch_hit) begin
        inst <= imem_rdata;
      end
      if (exec_step) begin
        if (misaligned) begin
          addr_err <= 1'b1;
        end else begin
          pc <= pc_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetches are queued by the stimulus
// and popped by a negedge monitor whenever a fetch handshake completes.
module tb_pc_fetch_unit;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Branch;
  logic [31:0] rs_data;
  logic        step;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;

  logic        req2;
  logic [31:0] addr2;
  logic [31:0] rdata2;
  logic [31:0] inst2;
  logic        valid2;
  logic [31:0] pc2;
  logic [31:0] pc4_2;
  logic        err2;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t sb2[$];
  exp_t pend_e;
  logic pend = 1'b0;
  logic mon2_on = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    case (a)
      32'h0000_0040: memw = 32'h0000_FFFE;
      32'h1000_0000: memw = 32'h0000_0010;
      default:       memw = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign imem_rdata = memw(imem_addr);
  assign rdata2     = memw(addr2);

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .Branch(Branch), .rs_data(rs_data), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .inst(inst), .inst_valid(inst_valid), .pc(pc),
    .pc_plus4(pc_plus4), .addr_err(addr_err)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .Branch(2'b00), .rs_data(32'h0), .step(1'b1),
    .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
    .imem_ready(1'b1), .inst(inst2), .inst_valid(valid2), .pc(pc2),
    .pc_plus4(pc4_2), .addr_err(err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] a4);
    exp_t e;
    e.addr = a;
    e.pc4  = a4;
    e.inst = memw(a);
    return e;
  endfunction

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (inst_valid) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic wait_sb(input string name);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (sb.size() == 0) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic do_exec(input logic [1:0] br, input logic [31:0] rs,
                         input logic [31:0] nxt, input logic [31:0] nxt4);
    wait_valid("exec_wait");
    Branch  = br;
    rs_data = rs;
    step    = 1'b1;
    sb.push_back(mk(nxt, nxt4));
    @(posedge clk); #1;
    step    = 1'b0;
    Branch  = 2'b00;
    rs_data = 32'hDEAD_BEEF;
  endtask

  // Monitor for the main DUT
  always @(negedge clk) begin
    if (pend && inst_valid) begin
      chk("inst", inst, pend_e.inst);
      chk("exec_pc", pc, pend_e.addr);
      pend = 1'b0;
    end
    if (imem_req && imem_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_fetch: got addr %h, expected no fetch", imem_addr);
      end else begin
        pend_e = sb.pop_front();
        chk("fetch_addr", imem_addr, pend_e.addr);
        chk("pc_plus4", pc_plus4, pend_e.pc4);
        pend = 1'b1;
      end
    end
  end

  // Monitor for the wrap-around DUT; stops once its expected fetches are consumed
  always @(negedge clk) begin
    if (mon2_on && req2) begin
      if (sb2.size() != 0) begin
        exp_t e2;
        e2 = sb2.pop_front();
        chk("wrap_addr", addr2, e2.addr);
        chk("wrap_pc_plus4", pc4_2, e2.pc4);
        chk("wrap_err", {31'd0, err2}, 32'd0);
      end
      if (sb2.size() == 0) mon2_on = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    imem_ready = 1'b1;
    step       = 1'b1;
    Branch     = 2'b00;
    rs_data    = 32'h0;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    // Sequential fetch, zero-wait memory
    sb.push_back(mk(32'h0, 32'h4));
    sb.push_back(mk(32'h4, 32'h8));
    sb.push_back(mk(32'h8, 32'hC));
    sb.push_back(mk(32'hC, 32'h10));
    sb2.push_back(mk(32'hFFFF_FFFC, 32'h0));
    sb2.push_back(mk(32'h0, 32'h4));
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    begin
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
        if (pc == 32'hC && inst_valid) ok = 1;
        else begin @(posedge clk); #1; end
      end
      if (!ok) fail_now("seq_reach_c");
    end
    chk("seq_sb_empty", sb.size(), 32'd0);
    chk("wrap_done", sb2.size(), 32'd0);
    chk("wrap_err_after", {31'd0, err2}, 32'd0);

    // Wait states at 0x10
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      step = 1'b0;
      chk("ws_req", {31'd0, imem_req}, 32'd1);
      chk("ws_addr", imem_addr, 32'h10);
    end
    sb.push_back(mk(32'h10, 32'h14));
    imem_ready = 1'b1;
    @(posedge clk); #1;
    chk("ws_valid", {31'd0, inst_valid}, 32'd1);

    // Branch and jump targets
    do_exec(2'b11, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044);
    do_exec(2'b01, 32'h0,         32'h0000_003C, 32'h0000_0040);
    do_exec(2'b11, 32'h1000_0000, 32'h1000_0000, 32'h1000_0004);
    do_exec(2'b10, 32'h0,         32'h1000_0040, 32'h1000_0044);
    do_exec(2'b11, 32'h0000_0200, 32'h0000_0200, 32'h0000_0204);
    wait_valid("valid_200");

    // Misaligned register jump halts fetch
    Branch  = 2'b11;
    rs_data = 32'h0000_0202;
    step    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("halt_err", {31'd0, addr_err}, 32'd1);
      chk("halt_pc", pc, 32'h200);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, inst_valid}, 32'd0);
    end
    step   = 1'b0;
    Branch = 2'b00;

    // Leave HALT through reset, then stall a fetch at 0x24 and reset mid-fetch
    reset = 1'b0;
    #1;
    chk("halt_rst_err", {31'd0, addr_err}, 32'd0);
    sb.push_back(mk(32'h0, 32'h4));
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    wait_valid("valid_0");
    imem_ready = 1'b0;
    Branch     = 2'b11;
    rs_data    = 32'h24;
    step       = 1'b1;
    @(posedge clk); #1;
    step   = 1'b0;
    Branch = 2'b00;
    chk("stall_req", {31'd0, imem_req}, 32'd1);
    chk("stall_addr", imem_addr, 32'h24);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    #2;
    imem_ready = 1'b1;
    sb.push_back(mk(32'h0, 32'h4));
    reset = 1'b1;
    @(posedge clk); #1;
    wait_sb("refetch");
    @(posedge clk); #1;
    wait_valid("refetch_valid");
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
